// File: rtl/ctc_access_sched_if.sv
// ctc_access_sched_if
// Purpose: groups the requester command handshake and the CTC register bus
//          used by ctc_access_sched.
// Signals:
//   rq_valid[1:0] / rq_ready[1:0]      command valid / one-cycle accept per requester
//   rq0_chan, rq0_mode, rq0_init       requester-0 (CPU) command payload
//   rq1_chan, rq1_mode, rq1_init       requester-1 (system agent) command payload
//   ctc_rd_en, ctc_wr_en               CTC read / write strobes
//   ctc_addr, ctc_wdata, ctc_rdata     CTC address and data
// Modports: master = requesters + CTC model side, slave = scheduler side.
interface ctc_access_sched_if;
    logic [1:0]  rq_valid;
    logic [1:0]  rq_ready;
    logic        rq0_chan;
    logic [15:0] rq0_mode;
    logic [15:0] rq0_init;
    logic        rq1_chan;
    logic [15:0] rq1_mode;
    logic [15:0] rq1_init;
    logic        ctc_rd_en;
    logic        ctc_wr_en;
    logic [2:0]  ctc_addr;
    logic [15:0] ctc_wdata;
    logic [15:0] ctc_rdata;

    modport master (
        output rq_valid, rq0_chan, rq0_mode, rq0_init,
        output rq1_chan, rq1_mode, rq1_init, ctc_rdata,
        input  rq_ready, ctc_rd_en, ctc_wr_en, ctc_addr, ctc_wdata
    );

    modport slave (
        input  rq_valid, rq0_chan, rq0_mode, rq0_init,
        input  rq1_chan, rq1_mode, rq1_init, ctc_rdata,
        output rq_ready, ctc_rd_en, ctc_wr_en, ctc_addr, ctc_wdata
    );
endinterface

// File: rtl/ctc_access_sched.sv
// ctc_access_sched
// Purpose: register-access scheduler for the two-channel CTC. Arbitrates
//          two requesters round-robin, issues mode then init writes for the
//          granted command, and on a CTC terminal pulse reads that channel's
//          status register, latches it and raises a sticky interrupt.
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   bus (slave)           requester handshake + CTC register bus
//   ctc_cout[1:0]         active-low terminal pulses per channel
//   irq[1:0], irq_clr     sticky per-channel interrupt, write-1-to-clear
//   stat_cap0/1           last status captured per channel
//   busy                  FSM not in IDLE
//
// state      | meaning
// -----------+-------------------------------------------------------------
// S_IDLE     | bus quiet; serve pending status reads first, else grant a command
// S_WR_MODE  | write mode word to the channel's mode register
// S_WR_INIT  | write initial value to the channel's init register
// S_STAT_RD  | read strobe on the channel's mode/status register
// S_STAT_CAP | capture read data, set the channel's interrupt
module ctc_access_sched #(
    parameter logic [2:0] MODE_ADDR0 = 3'b000,
    parameter logic [2:0] MODE_ADDR1 = 3'b010,
    parameter logic [2:0] INIT_ADDR0 = 3'b100,
    parameter logic [2:0] INIT_ADDR1 = 3'b110
) (
    input  logic                       clock,
    input  logic                       reset,
    ctc_access_sched_if.slave          bus,
    input  logic [1:0]                 ctc_cout,
    output logic [1:0]                 irq,
    input  logic [1:0]                 irq_clr,
    output logic [15:0]                stat_cap0,
    output logic [15:0]                stat_cap1,
    output logic                       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_MODE,
        S_WR_INIT,
        S_STAT_RD,
        S_STAT_CAP
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        rr_ptr;       // requester favoured when both are valid
    logic        cur_chan;
    logic [15:0] cur_mode;
    logic [15:0] cur_init;
    logic [1:0]  pend;
    logic        grant_en;
    logic        winner;
    logic [1:0]  chan_oh;
    logic [1:0]  pend_clr;
    logic [1:0]  irq_set;

    // Status reads take precedence, so a command is only granted with no pend.
    always_comb begin
        grant_en = 1'b0;
        winner   = 1'b0;
        chan_oh  = cur_chan ? 2'b10 : 2'b01;
        if (state == S_IDLE && pend == 2'b00 && !reset && bus.rq_valid != 2'b00) begin
            grant_en = 1'b1;
        end
        if (bus.rq_valid == 2'b11) begin
            winner = rr_ptr;
        end else begin
            winner = bus.rq_valid[1];
        end
        pend_clr = (state == S_STAT_RD)  ? chan_oh : 2'b00;
        irq_set  = (state == S_STAT_CAP) ? chan_oh : 2'b00;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (pend != 2'b00) begin
                    state_nxt = S_STAT_RD;
                end else if (grant_en) begin
                    state_nxt = S_WR_MODE;
                end
            end
            S_WR_MODE:  state_nxt = S_WR_INIT;
            S_WR_INIT:  state_nxt = S_IDLE;
            S_STAT_RD:  state_nxt = S_STAT_CAP;
            S_STAT_CAP: state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.rq_ready  = 2'b00;
        bus.ctc_rd_en = 1'b0;
        bus.ctc_wr_en = 1'b0;
        bus.ctc_addr  = 3'b000;
        bus.ctc_wdata = 16'h0000;
        busy          = (state != S_IDLE);
        if (grant_en) begin
            bus.rq_ready = winner ? 2'b10 : 2'b01;
        end
        case (state)
            S_WR_MODE: begin
                bus.ctc_wr_en = 1'b1;
                bus.ctc_addr  = cur_chan ? MODE_ADDR1 : MODE_ADDR0;
                bus.ctc_wdata = cur_mode;
            end
            S_WR_INIT: begin
                bus.ctc_wr_en = 1'b1;
                bus.ctc_addr  = cur_chan ? INIT_ADDR1 : INIT_ADDR0;
                bus.ctc_wdata = cur_init;
            end
            S_STAT_RD: begin
                bus.ctc_rd_en = 1'b1;
                bus.ctc_addr  = cur_chan ? MODE_ADDR1 : MODE_ADDR0;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr    <= 1'b0;
            cur_chan  <= 1'b0;
            cur_mode  <= 16'h0000;
            cur_init  <= 16'h0000;
            pend      <= 2'b00;
            irq       <= 2'b00;
            stat_cap0 <= 16'h0000;
            stat_cap1 <= 16'h0000;
        end else begin
            // A new pulse wins over the clear, so a pulse landing during its
            // own read schedules a second read.
            pend <= (pend & ~pend_clr) | ~ctc_cout;
            irq  <= (irq & ~irq_clr) | irq_set;
            if (state == S_IDLE) begin
                if (pend != 2'b00) begin
                    cur_chan <= !pend[0];
                end else if (grant_en) begin
                    cur_chan <= winner ? bus.rq1_chan : bus.rq0_chan;
                    cur_mode <= winner ? bus.rq1_mode : bus.rq0_mode;
                    cur_init <= winner ? bus.rq1_init : bus.rq0_init;
                    rr_ptr   <= !winner;
                end
            end
            if (state == S_STAT_CAP) begin
                if (cur_chan) begin
                    stat_cap1 <= bus.ctc_rdata;
                end else begin
                    stat_cap0 <= bus.ctc_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_ctc_access_sched.sv
// tb_ctc_access_sched
// Purpose: self-checking bench for ctc_access_sched. Expected grants and CTC
//          bus transactions are queued when stimulus is driven and compared
//          by a negedge monitor as the scheduler produces them.
// Ports: none (top-level bench).
module tb_ctc_access_sched;

    typedef struct packed {
        logic        rd;
        logic [2:0]  addr;
        logic [15:0] data;
    } bus_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  ctc_cout = 2'b11;
    logic [1:0]  irq_clr = 2'b00;
    logic [1:0]  irq;
    logic [15:0] stat_cap0;
    logic [15:0] stat_cap1;
    logic        busy;

    logic        v0 = 1'b0;
    logic        v1 = 1'b0;
    logic        p_chan [2];
    logic [15:0] p_mode [2];
    logic [15:0] p_init [2];
    logic [15:0] rdata = 16'h0000;

    bus_t        bq [$];
    logic [1:0]  gq [$];
    int          gcyc [$];
    int          cyc;
    int          n_chk;
    int          n_err;
    logic        mon_en = 1'b0;

    always #5 clock = ~clock;

    ctc_access_sched_if bus ();

    assign bus.rq_valid  = {v1, v0};
    assign bus.rq0_chan  = p_chan[0];
    assign bus.rq0_mode  = p_mode[0];
    assign bus.rq0_init  = p_init[0];
    assign bus.rq1_chan  = p_chan[1];
    assign bus.rq1_mode  = p_mode[1];
    assign bus.rq1_init  = p_init[1];
    assign bus.ctc_rdata = rdata;

    ctc_access_sched dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus.slave),
        .ctc_cout  (ctc_cout),
        .irq       (irq),
        .irq_clr   (irq_clr),
        .stat_cap0 (stat_cap0),
        .stat_cap1 (stat_cap1),
        .busy      (busy)
    );

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_cmd(input logic ch, input logic [15:0] m, input logic [15:0] i);
        bq.push_back({1'b0, (ch ? 3'b010 : 3'b000), m});
        bq.push_back({1'b0, (ch ? 3'b110 : 3'b100), i});
    endtask

    task automatic push_rd(input logic ch);
        bq.push_back({1'b1, (ch ? 3'b010 : 3'b000), 16'h0000});
    endtask

    task automatic do_reset();
        tick();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Holds valid with a stable payload until accepted, then drops it.
    task automatic drive_req(input int r, input logic ch, input logic [15:0] m, input logic [15:0] i);
        bit got;
        tick();
        p_chan[r] = ch;
        p_mode[r] = m;
        p_init[r] = i;
        if (r == 0) v0 = 1'b1; else v1 = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clock);
            if (bus.rq_ready[r]) begin
                got = 1'b1;
                gcyc.push_back(cyc);
            end
        end
        if (!got) chk("grant_timeout", 32'd0, 32'd1);
        tick();
        if (r == 0) v0 = 1'b0; else v1 = 1'b0;
    endtask

    always @(negedge clock) begin
        bus_t       e;
        logic [1:0] g;
        if (mon_en) begin
            if (bus.rq_ready != 2'b00) begin
                if (gq.size() == 0) begin
                    chk("grant_unexp", 32'(bus.rq_ready), 32'd0);
                end else begin
                    g = gq.pop_front();
                    chk("grant", 32'(bus.rq_ready), 32'(g));
                end
            end
            if (bus.ctc_rd_en || bus.ctc_wr_en) begin
                chk("rd_wr_excl", 32'(bus.ctc_rd_en & bus.ctc_wr_en), 32'd0);
                if (bq.size() == 0) begin
                    chk("bus_unexp", 32'({bus.ctc_rd_en, bus.ctc_wr_en}), 32'd0);
                end else begin
                    e = bq.pop_front();
                    chk("bus_kind", 32'(bus.ctc_rd_en), 32'(e.rd));
                    chk("bus_addr", 32'(bus.ctc_addr), 32'(e.addr));
                    if (!e.rd) chk("bus_wdata", 32'(bus.ctc_wdata), 32'(e.data));
                end
            end else if (!busy) begin
                chk("idle_bus", 32'({bus.ctc_addr, bus.ctc_wdata}), 32'd0);
            end
        end
    end

    initial begin
        bit seen;
        p_chan[0] = 1'b0; p_chan[1] = 1'b0;
        p_mode[0] = '0;   p_mode[1] = '0;
        p_init[0] = '0;   p_init[1] = '0;

        // reset state
        tick();
        tick();
        chk("rst_ready", 32'(bus.rq_ready), 32'd0);
        chk("rst_strobes", 32'({bus.ctc_rd_en, bus.ctc_wr_en}), 32'd0);
        chk("rst_addr_data", 32'({bus.ctc_addr, bus.ctc_wdata}), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_stat", {stat_cap1, stat_cap0}, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset  = 1'b0;
        mon_en = 1'b1;

        // single command from requester 0, exact cycle placement
        gq.push_back(2'b01);
        push_cmd(1'b0, 16'h0002, 16'h0010);
        drive_req(0, 1'b0, 16'h0002, 16'h0010);
        @(negedge clock);
        chk("t1_mode_wr", 32'({bus.ctc_wr_en, bus.ctc_addr, bus.ctc_wdata}), {12'd0, 1'b1, 3'b000, 16'h0002});
        @(negedge clock);
        chk("t1_init_wr", 32'({bus.ctc_wr_en, bus.ctc_addr, bus.ctc_wdata}), {12'd0, 1'b1, 3'b100, 16'h0010});
        @(negedge clock);
        chk("t1_idle_busy", 32'(busy), 32'd0);

        // contention: both requesters twice, alternating grants 3 cycles apart
        do_reset();
        gq.push_back(2'b01); gq.push_back(2'b10); gq.push_back(2'b01); gq.push_back(2'b10);
        push_cmd(1'b0, 16'h0011, 16'h0100);
        push_cmd(1'b1, 16'h0022, 16'h0200);
        push_cmd(1'b1, 16'h0033, 16'h0300);
        push_cmd(1'b0, 16'h0044, 16'h0400);
        gcyc.delete();
        fork
            begin
                drive_req(0, 1'b0, 16'h0011, 16'h0100);
                drive_req(0, 1'b1, 16'h0033, 16'h0300);
            end
            begin
                drive_req(1, 1'b1, 16'h0022, 16'h0200);
                drive_req(1, 1'b0, 16'h0044, 16'h0400);
            end
        join
        chk("t2_grant_count", 32'(gcyc.size()), 32'd4);
        if (gcyc.size() == 4) begin
            for (int k = 1; k < 4; k++) chk("t2_grant_gap", 32'(gcyc[k] - gcyc[k-1]), 32'd3);
        end
        repeat (4) tick();
        chk("t2_bq_drained", 32'(bq.size()), 32'd0);

        // terminal pulse on channel 0
        rdata = 16'h0001;
        tick();
        ctc_cout = 2'b10;
        push_rd(1'b0);
        tick();
        ctc_cout = 2'b11;
        repeat (6) tick();
        chk("t3_stat_cap0", 32'(stat_cap0), 32'h0001);
        chk("t3_stat_cap1", 32'(stat_cap1), 32'h0000);
        chk("t3_irq", 32'(irq), 32'h1);

        // clear in the capture cycle loses to the set; a later clear works
        rdata = 16'h00A5;
        tick();
        ctc_cout = 2'b10;
        push_rd(1'b0);
        tick();
        ctc_cout = 2'b11;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clock);
            if (bus.ctc_rd_en) seen = 1'b1;
        end
        chk("t5_rd_seen", 32'(seen), 32'd1);
        tick();
        irq_clr = 2'b01;
        tick();
        irq_clr = 2'b00;
        @(negedge clock);
        chk("t5_irq_kept", 32'(irq), 32'h1);
        chk("t5_stat_cap0", 32'(stat_cap0), 32'h00A5);
        tick();
        irq_clr = 2'b01;
        tick();
        irq_clr = 2'b00;
        @(negedge clock);
        chk("t5_irq_cleared", 32'(irq), 32'h0);

        // channel-1 pulse during WR_MODE: write finishes, then status read
        do_reset();
        rdata = 16'hBEEF;
        gq.push_back(2'b01);
        push_cmd(1'b1, 16'h0055, 16'h0500);
        push_rd(1'b1);
        fork
            drive_req(0, 1'b1, 16'h0055, 16'h0500);
            begin
                seen = 1'b0;
                for (int k = 0; k < 40 && !seen; k++) begin
                    @(negedge clock);
                    if (bus.rq_ready[0]) seen = 1'b1;
                end
                tick();
                ctc_cout = 2'b01;
                tick();
                ctc_cout = 2'b11;
            end
        join
        repeat (8) tick();
        chk("t4_stat_cap1", 32'(stat_cap1), 32'hBEEF);
        chk("t4_irq", 32'(irq), 32'h2);
        chk("t4_bq_drained", 32'(bq.size()), 32'd0);

        // reset during WR_MODE: no init write follows
        do_reset();
        gq.push_back(2'b01);
        bq.push_back({1'b0, 3'b000, 16'h0077});
        drive_req(0, 1'b0, 16'h0077, 16'h0700);
        reset = 1'b1;
        @(negedge clock);
        chk("t6_mode_wr", 32'(bus.ctc_wr_en), 32'd1);
        tick();
        reset = 1'b0;
        @(negedge clock);
        chk("t6_wr_after_rst", 32'(bus.ctc_wr_en), 32'd0);
        chk("t6_busy_after_rst", 32'(busy), 32'd0);
        repeat (6) tick();

        chk("end_bq_empty", 32'(bq.size()), 32'd0);
        chk("end_gq_empty", 32'(gq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
